// File: rtl/shift_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : shift_seq_ctrl
// Description : Command sequencer for an external 4-bit universal shift
//               register (load / shift right / shift left / rotate right).
//               Define SHIFT_SEQ_CTRL_ROTATE_EN to support op 11 (rotate).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_count,
  input  logic [3:0] cmd_data,
  input  logic       cmd_fill,
  input  logic [3:0] q_parallel,
  output logic [1:0] sel,
  output logic [3:0] d_parallel,
  output logic       d_right,
  output logic       d_left,
  output logic       done,
  output logic [3:0] result,
  output logic       err
);

  localparam logic [1:0] c_OP_LOAD = 2'b00;
  localparam logic [1:0] c_OP_SHR  = 2'b01;
  localparam logic [1:0] c_OP_SHL  = 2'b10;
  localparam logic [1:0] c_OP_ROTR = 2'b11;

  localparam logic [1:0] c_SEL_HOLD  = 2'b00;
  localparam logic [1:0] c_SEL_RIGHT = 2'b01;
  localparam logic [1:0] c_SEL_LEFT  = 2'b10;
  localparam logic [1:0] c_SEL_LOAD  = 2'b11;

`ifdef SHIFT_SEQ_CTRL_ROTATE_EN
  localparam logic c_ROT_EN = 1'b1;
`else
  localparam logic c_ROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  logic [2:0] r_cnt;
  logic [1:0] r_sel;
  logic [3:0] r_d_parallel;
  logic       r_d_right;
  logic       r_d_left;
  logic       r_rot;
  logic       r_done;
  logic       r_err;
  logic [3:0] r_result;
  logic       w_accept;

  assign w_accept  = cmd_valid && (r_state == S_IDLE);
  assign cmd_ready = (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_sel        <= c_SEL_HOLD;
      r_d_parallel <= 4'd0;
      r_d_right    <= 1'b0;
      r_d_left     <= 1'b0;
      r_rot        <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_result     <= 4'd0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sel        <= c_SEL_HOLD;
          r_d_parallel <= 4'd0;
          r_d_right    <= 1'b0;
          r_d_left     <= 1'b0;
          r_rot        <= 1'b0;
          if (w_accept) begin
            // Command fields are captured straight into the output registers.
            if (cmd_op == c_OP_LOAD) begin
              r_state      <= S_LOAD;
              r_sel        <= c_SEL_LOAD;
              r_d_parallel <= cmd_data;
            end else if ((cmd_op == c_OP_ROTR) && !c_ROT_EN) begin
              r_err <= 1'b1;
            end else if (cmd_count == 3'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_SHIFT;
              r_cnt     <= cmd_count;
              r_sel     <= (cmd_op == c_OP_SHL) ? c_SEL_LEFT : c_SEL_RIGHT;
              r_d_right <= (cmd_op == c_OP_SHR) ? cmd_fill : 1'b0;
              r_d_left  <= (cmd_op == c_OP_SHL) ? cmd_fill : 1'b0;
              r_rot     <= (cmd_op == c_OP_ROTR);
            end
          end
        end
        S_LOAD: begin
          r_state      <= S_DONE;
          r_done       <= 1'b1;
          r_sel        <= c_SEL_HOLD;
          r_d_parallel <= 4'd0;
        end
        S_SHIFT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_state   <= S_DONE;
            r_done    <= 1'b1;
            r_sel     <= c_SEL_HOLD;
            r_d_right <= 1'b0;
            r_d_left  <= 1'b0;
            r_rot     <= 1'b0;
          end
        end
        S_DONE: begin
          r_result <= q_parallel;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sel        = r_sel;
  assign d_parallel = r_d_parallel;
  // Rotate feeds bit 0 back to bit 3 live, so it must bypass the register.
  assign d_right    = r_rot ? q_parallel[0] : r_d_right;
  assign d_left     = r_d_left;
  assign done       = r_done;
  assign result     = r_result;
  assign err        = r_err;

endmodule
`default_nettype wire
